// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR random-number generator: FSM states,
// maximal-length tap masks and the power-of-two range mask used for rejection sampling.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } fsm_t;

    // Maximal-length Galois masks for widths 8, 16 and 32.
    localparam logic [31:0] TAP_TABLE [3] = '{32'h0000_00B8, 32'h0000_B400, 32'h8020_0003};

    function automatic logic [31:0] default_taps(input int unsigned w);
        case (w)
            8:       return TAP_TABLE[0];
            32:      return TAP_TABLE[2];
            default: return TAP_TABLE[1];
        endcase
    endfunction

    // Smallest 2^k-1 covering limit-1; limit 0 stands for the full 2^w range.
    function automatic logic [31:0] range_mask(input logic [31:0] lim, input int unsigned w);
        logic [31:0] m;
        if (lim == 32'd0) begin
            if (w >= 32)
                return '1;
            return (32'd1 << w) - 32'd1;
        end
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (m < lim - 32'd1)
                m = {m[30:0], 1'b1};
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with run-time seed load; an all-zero state (loaded or
// otherwise reached) is replaced by SEED and flagged with a one-cycle zero_fix pulse.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             zero_fix
);

    logic [WIDTH-1:0] state_step;

    assign state_step = (state >> 1) ^ (state[0] ? TAPS : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEED;
            zero_fix <= 1'b0;
        end else begin
            zero_fix <= 1'b0;
            if (load) begin
                if (load_val == '0) begin
                    state    <= SEED;
                    zero_fix <= 1'b1;
                end else begin
                    state <= load_val;
                end
            end else if (state == '0) begin
                state    <= SEED;
                zero_fix <= 1'b1;
            end else if (step) begin
                state <= state_step;
            end
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// Bounded-range random draws in [0, limit) by rejection sampling over a Galois LFSR,
// with a forced fallback after MAX_TRIES candidates; the raw state is also exposed.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               OUT_WIDTH = 8,
    parameter int               MAX_TRIES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_en,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_in,
    input  logic                 req,
    input  logic [OUT_WIDTH-1:0] limit,
    output logic                 busy,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] value,
    output logic                 timeout,
    output logic                 zero_fix,
    output logic [WIDTH-1:0]     state_out
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    fsm_t                 fsm, fsm_nxt;
    logic [TW-1:0]        tries, tries_nxt;
    logic [OUT_WIDTH-1:0] lim_q, lim_nxt;
    logic [OUT_WIDTH-1:0] mask_q, mask_nxt;
    logic [OUT_WIDTH-1:0] value_nxt;
    logic                 timeout_nxt;
    logic [OUT_WIDTH-1:0] cand;
    logic                 step;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (state_out),
        .zero_fix (zero_fix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm     <= IDLE;
            tries   <= '0;
            lim_q   <= '0;
            mask_q  <= '0;
            value   <= '0;
            timeout <= 1'b0;
        end else begin
            fsm     <= fsm_nxt;
            tries   <= tries_nxt;
            lim_q   <= lim_nxt;
            mask_q  <= mask_nxt;
            value   <= value_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        fsm_nxt     = fsm;
        tries_nxt   = tries;
        lim_nxt     = lim_q;
        mask_nxt    = mask_q;
        value_nxt   = value;
        timeout_nxt = timeout;
        step        = 1'b0;
        busy        = 1'b1;
        valid       = 1'b0;
        cand        = state_out[OUT_WIDTH-1:0] & mask_q;
        case (fsm)
            IDLE: begin
                busy = 1'b0;
                step = step_en | req;
                if (req) begin
                    lim_nxt   = limit;
                    mask_nxt  = OUT_WIDTH'(range_mask(32'(limit), OUT_WIDTH));
                    tries_nxt = '0;
                    fsm_nxt   = DRAW;
                end
            end
            DRAW: begin
                step = 1'b1;
                if (lim_q == '0 || cand < lim_q) begin
                    value_nxt   = cand;
                    timeout_nxt = 1'b0;
                    fsm_nxt     = DONE;
                end else if (tries == TW'(MAX_TRIES - 1)) begin
                    // mask < 2*limit, so one subtraction lands inside the range
                    value_nxt   = cand - lim_q;
                    timeout_nxt = 1'b1;
                    fsm_nxt     = DONE;
                end else begin
                    tries_nxt = tries + TW'(1);
                end
            end
            DONE: begin
                valid   = 1'b1;
                fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lfsr_rng.sv
module tb_lfsr_rng;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [7:0]  limit = '0;

    logic        busy0, valid0, timeout0, zero_fix0;
    logic [7:0]  value0;
    logic [15:0] state0;
    logic        busy1, valid1, timeout1, zero_fix1;
    logic [7:0]  value1;
    logic [15:0] state1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_rng dut (
        .clk(clk), .reset(reset), .step_en(step_en), .seed_load(seed_load),
        .seed_in(seed_in), .req(req0), .limit(limit), .busy(busy0), .valid(valid0),
        .value(value0), .timeout(timeout0), .zero_fix(zero_fix0), .state_out(state0)
    );

    lfsr_rng #(.MAX_TRIES(1)) dut1 (
        .clk(clk), .reset(reset), .step_en(step_en), .seed_load(seed_load),
        .seed_in(seed_in), .req(req1), .limit(limit), .busy(busy1), .valid(valid1),
        .value(value1), .timeout(timeout1), .zero_fix(zero_fix1), .state_out(state1)
    );

    typedef struct {
        logic       fast;
        logic [7:0] lim;
        logic [7:0] exp_val;
        logic       exp_to;
        int         exp_lat;
    } vec_t;

    vec_t        vecs [19];
    logic [15:0] step_seq [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step_en = 1'b0;
        seed_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request after a falling edge and waits (bounded) for valid.
    task automatic do_draw(input logic fast, input logic [7:0] lim,
                           output logic [7:0] got_val, output logic got_to,
                           output int lat, output int busy_cnt);
        logic v, b;
        @(negedge clk);
        limit = lim;
        if (fast) req1 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        lat = 1;
        b = fast ? busy1 : busy0;
        v = fast ? valid1 : valid0;
        busy_cnt = b ? 1 : 0;
        while (!v && lat < 40) begin
            @(negedge clk);
            lat++;
            b = fast ? busy1 : busy0;
            v = fast ? valid1 : valid0;
            if (b) busy_cnt++;
        end
        if (!v) begin
            n_checks++;
            n_fail++;
            $display("FAIL draw_timeout: no valid within %0d cycles (limit %0d)", lat, lim);
        end
        got_val = fast ? value1 : value0;
        got_to  = fast ? timeout1 : timeout0;
    endtask

    initial begin
        logic [7:0] gv;
        logic       gt;
        int         lat, bc;

        // fast, limit, value, timeout, cycles from request to valid
        vecs[0]  = '{1'b0, 8'd0,   8'h70, 1'b0, 2};
        vecs[1]  = '{1'b0, 8'd100, 8'd56, 1'b0, 3};
        vecs[2]  = '{1'b0, 8'd1,   8'd0,  1'b0, 2};
        vecs[3]  = '{1'b0, 8'd200, 8'd112, 1'b0, 2};
        vecs[4]  = '{1'b0, 8'd128, 8'd112, 1'b0, 2};
        vecs[5]  = '{1'b0, 8'd113, 8'd112, 1'b0, 2};
        vecs[6]  = '{1'b0, 8'd112, 8'd56, 1'b0, 3};
        vecs[7]  = '{1'b0, 8'd16,  8'd0,  1'b0, 2};
        vecs[8]  = '{1'b0, 8'd2,   8'd0,  1'b0, 2};
        vecs[9]  = '{1'b0, 8'd50,  8'd48, 1'b0, 2};
        vecs[10] = '{1'b0, 8'd40,  8'd28, 1'b0, 4};
        vecs[11] = '{1'b0, 8'd33,  8'd28, 1'b0, 4};
        vecs[12] = '{1'b0, 8'd3,   8'd0,  1'b0, 2};
        vecs[13] = '{1'b0, 8'd5,   8'd0,  1'b0, 2};
        vecs[14] = '{1'b1, 8'd100, 8'd12, 1'b1, 2};
        vecs[15] = '{1'b1, 8'd40,  8'd8,  1'b1, 2};
        vecs[16] = '{1'b1, 8'd0,   8'h70, 1'b0, 2};
        vecs[17] = '{1'b1, 8'd113, 8'd112, 1'b0, 2};
        vecs[18] = '{1'b1, 8'd112, 8'd0,  1'b1, 2};

        step_seq = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};

        // Reset state
        do_reset();
        chk("rst_state", 32'(state0), 32'hACE1);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_value", 32'(value0), 0);
        chk("rst_timeout", 32'(timeout0), 0);
        chk("rst_zero_fix", 32'(zero_fix0), 0);

        // Free-running steps
        step_en = 1'b1;
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("step_%0d", i), 32'(state0), 32'(step_seq[i]));
            chk($sformatf("step_quiet_%0d", i), 32'({busy0, valid0}), 0);
        end
        step_en = 1'b0;

        // Table-driven draws, each from a fresh reset
        for (int i = 0; i < 19; i++) begin
            do_reset();
            do_draw(vecs[i].fast, vecs[i].lim, gv, gt, lat, bc);
            chk($sformatf("v%0d_value", i), 32'(gv), 32'(vecs[i].exp_val));
            chk($sformatf("v%0d_timeout", i), 32'(gt), 32'(vecs[i].exp_to));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_lat));
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i),
                32'(vecs[i].fast ? {valid1, busy1} : {valid0, busy0}), 0);
            chk($sformatf("v%0d_value_held", i),
                32'(vecs[i].fast ? value1 : value0), 32'(vecs[i].exp_val));
        end

        // Zero seed is replaced by SEED, with a single zero_fix pulse
        do_reset();
        step_en = 1'b1;
        repeat (3) @(negedge clk);
        seed_load = 1'b1;
        seed_in = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        step_en = 1'b0;
        chk("zero_seed_state", 32'(state0), 32'hACE1);
        chk("zero_fix_pulse", 32'(zero_fix0), 1);
        @(negedge clk);
        chk("zero_fix_clear", 32'(zero_fix0), 0);
        do_draw(1'b0, 8'd1, gv, gt, lat, bc);
        chk("limit1_value", 32'(gv), 0);
        chk("limit1_timeout", 32'(gt), 0);

        // Non-zero seed load wins over a simultaneous step
        @(negedge clk);
        step_en = 1'b1;
        seed_load = 1'b1;
        seed_in = 16'h1234;
        @(negedge clk);
        seed_load = 1'b0;
        step_en = 1'b0;
        chk("seed_load_state", 32'(state0), 32'h1234);
        chk("seed_load_no_fix", 32'(zero_fix0), 0);

        // Reset in the first rejection cycle of a limit-100 draw
        do_reset();
        @(negedge clk);
        limit = 8'd100;
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        chk("mid_busy_before", 32'(busy0), 1);
        reset = 1'b1;
        #1;
        chk("mid_busy_drop", 32'(busy0), 0);
        chk("mid_state", 32'(state0), 32'hACE1);
        chk("mid_valid", 32'(valid0), 0);
        @(negedge clk);
        reset = 1'b0;
        bc = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid0) bc++;
        end
        chk("mid_no_valid", 32'(bc), 0);
        chk("mid_state_idle", 32'(state0), 32'hACE1);
        do_draw(1'b0, 8'd100, gv, gt, lat, bc);
        chk("after_rst_value", 32'(gv), 56);
        chk("after_rst_latency", 32'(lat), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
